alu_result_sel: RTL and testbench

//   Registered, parametrised N-to-1 result selector for the ALU output path.

---
 rtl/alu_result_sel.sv | 107 ++++++++++
 tb/tb_alu_result_sel.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_result_sel.sv
// rtl/alu_result_sel.sv - registered N-to-1 ALU result selector with manual and auto-scan modes
module alu_result_sel #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 6,
   parameter int SEL_W    = $clog2(CHANNELS),
   parameter int SCAN_DIV = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] din,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      mode,
   input  logic                      hold,
   output logic [WIDTH-1:0]          dout,
   output logic [SEL_W-1:0]          dout_chan,
   output logic                      dout_valid,
   output logic                      sel_err,
   output logic                      chan_chg
);

   localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);
   localparam logic [SEL_W:0]   CH_CNT   = (SEL_W + 1)'(CHANNELS);

   typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

   state_t           state, state_nxt;
   logic [SEL_W-1:0] index, idx_nxt;
   logic [DIV_W-1:0] div, div_nxt;
   logic [WIDTH-1:0] dout_nxt;
   logic [SEL_W-1:0] chan_nxt;
   logic             valid_nxt, err_nxt, chg_nxt;
   logic             sel_ok;
   logic [WIDTH-1:0] sel_data, idx_data;

   assign sel_ok   = ({1'b0, sel} < CH_CNT);
   assign sel_data = din[int'(sel)*WIDTH +: WIDTH];
   assign idx_data = din[int'(idx_nxt)*WIDTH +: WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         index      <= '0;
         div        <= '0;
         dout       <= '0;
         dout_chan  <= '0;
         dout_valid <= 1'b0;
         sel_err    <= 1'b0;
         chan_chg   <= 1'b0;
      end else begin
         state      <= state_nxt;
         index      <= idx_nxt;
         div        <= div_nxt;
         dout       <= dout_nxt;
         dout_chan  <= chan_nxt;
         dout_valid <= valid_nxt;
         sel_err    <= err_nxt;
         chan_chg   <= chg_nxt;
      end
   end

   // Scan output follows the next index so dout_chan equals the index register and each
   // channel is shown for exactly SCAN_DIV cycles.
   always_comb begin
      state_nxt = state;
      idx_nxt   = index;
      div_nxt   = div;
      dout_nxt  = dout;
      chan_nxt  = dout_chan;
      valid_nxt = dout_valid;
      err_nxt   = sel_err;
      chg_nxt   = 1'b0;
      if (!hold) begin
         if (!mode) begin
            state_nxt = MANUAL;
            if (sel_ok) begin
               dout_nxt  = sel_data;
               chan_nxt  = sel;
               valid_nxt = 1'b1;
               err_nxt   = 1'b0;
            end else begin
               dout_nxt  = '0;
               valid_nxt = 1'b0;
               err_nxt   = 1'b1;
            end
         end else begin
            state_nxt = SCAN;
            err_nxt   = 1'b0;
            valid_nxt = 1'b1;
            if (state != SCAN) begin
               idx_nxt = sel_ok ? sel : '0;
               div_nxt = '0;
            end else if (div == DIV_LAST) begin
               div_nxt = '0;
               idx_nxt = (index == LAST_IDX) ? '0 : index + 1'b1;
            end else begin
               div_nxt = div + 1'b1;
            end
            dout_nxt = idx_data;
            chan_nxt = idx_nxt;
         end
         chg_nxt = (chan_nxt != dout_chan);
      end
   end

endmodule

// File: tb/tb_alu_result_sel.sv
// tb/tb_alu_result_sel.sv - table-driven and sequence checks for alu_result_sel
module tb_alu_result_sel;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] din;
   logic [2:0]  sel;
   logic        mode, hold;
   logic [3:0]  dout;
   logic [2:0]  dout_chan;
   logic        dout_valid, sel_err, chan_chg;

   logic [15:0] din_b;
   logic [1:0]  sel_b;
   logic        mode_b;
   logic [3:0]  dout_b;
   logic [1:0]  chan_b;
   logic        valid_b, err_b, chg_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_result_sel #(.WIDTH(4), .CHANNELS(6), .SCAN_DIV(16)) dut (
      .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .hold(hold),
      .dout(dout), .dout_chan(dout_chan), .dout_valid(dout_valid),
      .sel_err(sel_err), .chan_chg(chan_chg)
   );

   alu_result_sel #(.WIDTH(4), .CHANNELS(4), .SCAN_DIV(1)) dut_b (
      .clk(clk), .rst(rst), .din(din_b), .sel(sel_b), .mode(mode_b), .hold(1'b0),
      .dout(dout_b), .dout_chan(chan_b), .dout_valid(valid_b),
      .sel_err(err_b), .chan_chg(chg_b)
   );

   typedef struct {
      logic       mode;
      logic [2:0] sel;
      logic       hold;
      logic [23:0] din;
      logic [3:0] dout;
      logic [2:0] chan;
      logic       valid;
      logic       err;
      logic       chg;
   } vec_t;

   vec_t       vecs [9];
   logic [3:0] chv [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_all(input string tag, input logic [3:0] d, input logic [2:0] c,
                            input logic v, input logic e, input logic g);
      check({tag, " dout"}, 32'(dout), 32'(d));
      check({tag, " chan"}, 32'(dout_chan), 32'(c));
      check({tag, " valid"}, 32'(dout_valid), 32'(v));
      check({tag, " err"}, 32'(sel_err), 32'(e));
      check({tag, " chg"}, 32'(chan_chg), 32'(g));
   endtask

   initial begin
      int pulses;
      logic [2:0] ec;

      chv = '{4'h1, 4'h5, 4'h7, 4'hA, 4'hE, 4'hF};
      //          mode  sel   hold  din         dout  chan  v     e     chg
      vecs[0] = '{1'b0, 3'd3, 1'b0, 24'hFEA751, 4'hA, 3'd3, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 3'd3, 1'b0, 24'hFEA751, 4'hA, 3'd3, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 3'd7, 1'b0, 24'hFEA751, 4'h0, 3'd3, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 3'd6, 1'b0, 24'hFEA751, 4'h0, 3'd3, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 3'd2, 1'b0, 24'hFEA751, 4'h7, 3'd2, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{1'b0, 3'd2, 1'b1, 24'hFEA351, 4'h7, 3'd2, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 3'd2, 1'b0, 24'hFEA351, 4'h3, 3'd2, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 3'd0, 1'b0, 24'hFEA751, 4'h1, 3'd0, 1'b1, 1'b0, 1'b1};
      vecs[8] = '{1'b0, 3'd5, 1'b0, 24'hFEA751, 4'hF, 3'd5, 1'b1, 1'b0, 1'b1};

      rst = 1'b1; din = 24'hFEA751; sel = '0; mode = 1'b0; hold = 1'b0;
      din_b = 16'h4321; sel_b = '0; mode_b = 1'b0;
      step(); step();
      check_all("reset", 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         mode = vecs[i].mode; sel = vecs[i].sel; hold = vecs[i].hold; din = vecs[i].din;
         step();
         check_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].chan,
                   vecs[i].valid, vecs[i].err, vecs[i].chg);
      end

      // Full scan round from channel 4, 16 cycles per channel
      mode = 1'b1; sel = 3'd4; pulses = 0;
      for (int j = 0; j <= 101; j++) begin
         step();
         ec = 3'((4 + j / 16) % 6);
         check($sformatf("scan%0d chan", j), 32'(dout_chan), 32'(ec));
         check($sformatf("scan%0d dout", j), 32'(dout), 32'(chv[ec]));
         check($sformatf("scan%0d chg", j), 32'(chan_chg), 32'((j % 16) == 0));
         if (j >= 1 && j <= 96 && chan_chg) pulses++;
      end
      check("scan round pulses", 32'(pulses), 32'd6);

      // Freeze mid-dwell, ch4 data changes are ignored
      hold = 1'b1; din = 24'hF2A751;
      for (int k = 0; k < 10; k++) begin
         step();
         check_all($sformatf("hold%0d", k), 4'hE, 3'd4, 1'b1, 1'b0, 1'b0);
      end
      hold = 1'b0; din = 24'hFEA751;
      for (int k = 1; k <= 11; k++) begin
         step();
         if (k < 11) check_all($sformatf("resume%0d", k), 4'hE, 3'd4, 1'b1, 1'b0, 1'b0);
         else        check_all("resume step", 4'hF, 3'd5, 1'b1, 1'b0, 1'b1);
      end

      mode = 1'b0; sel = 3'd1;
      step();
      check_all("to manual", 4'h5, 3'd1, 1'b1, 1'b0, 1'b1);
      mode = 1'b1; sel = 3'd6;
      for (int k = 0; k <= 16; k++) begin
         step();
         if (k == 0)       check_all("rescan entry", 4'h1, 3'd0, 1'b1, 1'b0, 1'b1);
         else if (k < 16)  check_all($sformatf("rescan%0d", k), 4'h1, 3'd0, 1'b1, 1'b0, 1'b0);
         else              check_all("rescan step", 4'h5, 3'd1, 1'b1, 1'b0, 1'b1);
      end

      step(); step(); step();
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_all("async rst", 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check_all("rst held", 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0; mode = 1'b0; sel = 3'd0;
      step();
      check_all("post rst cap", 4'h1, 3'd0, 1'b1, 1'b0, 1'b0);
      mode = 1'b1; sel = 3'd7;
      step();
      check_all("scan bad sel", 4'h1, 3'd0, 1'b1, 1'b0, 1'b0);

      // SCAN_DIV=1, four channels: advance every cycle
      mode_b = 1'b1; sel_b = 2'd2;
      for (int j = 0; j < 6; j++) begin
         step();
         check($sformatf("div1 %0d chan", j), 32'(chan_b), 32'((2 + j) % 4));
         check($sformatf("div1 %0d dout", j), 32'(dout_b), 32'((2 + j) % 4 + 1));
         check($sformatf("div1 %0d chg", j), 32'(chg_b), 32'd1);
         check($sformatf("div1 %0d valid", j), 32'(valid_b), 32'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
